period_meter: RTL and testbench
===============================

PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the period counter and period output, legal range 3..15.
REQ-002 SHALL have parameter LOCK_CNT, default 2, number of consecutive matching periods needed to declare lock, legal range 1..7.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port sig_in  input  1  divided-clock signal to be measured, asynchronous to clk.
REQ-006 SHALL have port period  output  CNT_W  last measured period in clk cycles.
REQ-007 SHALL have port period_valid  output  1  one-cycle pulse marking a new period value.
REQ-008 SHALL have port div_code  output  4  log2(period) when period is a power of two, else 4'hF.
REQ-009 SHALL have port locked  output  1  high while LOCK_CNT+1 consecutive periods have been equal.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on loss of sig_in edges (TIMEOUT_EN builds only, else tied 0).

Function
REQ-011 SHALL pass sig_in through a 2-FF synchronizer and detect rising edges on the synchronized value.
REQ-012 SHALL implement states IDLE (waiting for first edge), MEASURE (counting, unlocked) and LOCKED.
REQ-013 SHALL, on an edge in IDLE, load cnt=1, go to MEASURE and produce no period_valid.
REQ-014 SHALL increment cnt each cycle without an edge and saturate it at all-ones.
REQ-015 SHALL, on an edge in MEASURE/LOCKED, register period=cnt, pulse period_valid the next cycle, and reload cnt=1.
REQ-016 SHALL produce the period_valid pulse 4 clk cycles after the first clk edge that samples sig_in high.
REQ-017 SHALL increment match_cnt when a new period equals the previous one, otherwise reset it to 0.
REQ-018 SHALL go MEASURE->LOCKED and assert locked in the same cycle as the period_valid pulse on which match_cnt reaches LOCK_CNT.
REQ-019 SHALL go LOCKED->MEASURE on any mismatching period, deasserting locked with that period_valid pulse and clearing match_cnt.
REQ-020 SHALL treat a period captured at saturation (all-ones) as a mismatch that never counts toward lock.
REQ-021 SHALL update div_code in the same cycle as period: value k for period==2^k (1<=k<=CNT_W-1), 4'hF otherwise.

Reset
REQ-022 SHALL, while rst==0 at a clk edge, clear the synchronizer, cnt, match_cnt, period, div_code (4'hF), period_valid, locked and timeout, and enter IDLE.
REQ-023 SHALL discard any partial period when reset asserts mid-measurement, so the first edge after reset is treated as an IDLE edge.

Configuration
REQ-024 SHALL, with macro PERIOD_METER_TIMEOUT_EN defined, return to IDLE when cnt saturates without an edge, clearing locked and match_cnt and pulsing timeout for one cycle.
REQ-025 SHALL, without PERIOD_METER_TIMEOUT_EN, keep cnt saturated in the current state until the next edge, with timeout constant 0.

Structure
REQ-026 SHALL take the state enumeration and the DIV_CODE_NONE (4'hF) constant from shared package period_meter_pkg.
REQ-027 SHALL place the synchronizer and edge detector in sub-module sync_edge_det (ports clk, rst, d, rise).

Verification
REQ-028 SHALL verify that sig_in toggling every clk (period 2), with LOCK_CNT=2, gives period=2 and div_code=1 on every pulse, and locked=1 on the third period_valid.
REQ-029 SHALL verify that sig_in with period 16 (8 high, 8 low) gives period=16 and div_code=4, and locked=1 after 3 pulses.
REQ-030 SHALL verify that sig_in with period 6 gives period=6 and div_code=4'hF, and locks normally.
REQ-031 SHALL verify that a locked period-8 stream switched to period 4 gives period_valid with period=4 and locked=0 in the same cycle, and locked=1 again after 2 more matching periods.
REQ-032 SHALL verify that sig_in held low for 300 cycles with CNT_W=8 and TIMEOUT_EN pulses timeout once at cnt=255, clears locked and returns to IDLE; without the macro, the next edge yields period=255 and locked=0.
REQ-033 SHALL verify that rst=0 for one cycle mid-period clears all outputs, and the next edge produces no period_valid.

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding, div_code constant and the
// power-of-two decoder used by period_meter.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] DIV_CODE_NONE = 4'hF;

    // k when v == 2^k for 1 <= k <= w-1, else DIV_CODE_NONE.
    function automatic logic [3:0] div_code_of(
        input logic [14:0] v,
        input int          w
    );
        logic [3:0] r;
        r = DIV_CODE_NONE;
        for (int k = 1; k < 15; k++) begin
            if (k < w && v == (15'd1 << k)) begin
                r = 4'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: measured signal plus measurement results.
// master drives sig_in and observes results; slave is the meter side.
interface period_meter_if #(
    parameter int CNT_W = 8
);

    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic [3:0]       div_code;
    logic             locked;
    logic             timeout;

    modport master (
        output sig_in,
        input  period,
        input  period_valid,
        input  div_code,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output period_valid,
        output div_code,
        output locked,
        output timeout
    );

endinterface

// File: rtl/period_meter_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus registered rising-edge detect.
// Ports: clk, rst (sync, active-low), d (async input), rise (1-cycle pulse).
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    // sh[0], sh[1]: synchronizer; sh[2]: previous synchronized value
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh   <= '0;
            rise <= 1'b0;
        end else begin
            sh   <= {sh[1:0], d};
            rise <= sh[1] & ~sh[2];
        end
    end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures sig_in period in clk cycles, decodes
// power-of-two divisors and declares lock on repeated equal periods.
// Ports: clk, rst (sync, active-low), bus (period_meter_if.slave:
//   sig_in, period, period_valid, div_code, locked, timeout).
// Macro PERIOD_METER_TIMEOUT_EN: saturation of the counter without an
//   edge returns to IDLE and pulses timeout; otherwise timeout is 0.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    period_meter_if.slave        bus
);

    localparam logic [CNT_W-1:0] SAT = '1;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] period_n;
    logic [3:0]       div_n;
    logic [2:0]       match_cnt;
    logic [2:0]       match_cnt_n;
    logic             pend;
    logic             pend_n;
    logic             to_n;
    logic             hit;
    logic             rise;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // locked follows state one cycle late so it lines up with period_valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt              <= '0;
            match_cnt        <= '0;
            pend             <= 1'b0;
            bus.period       <= '0;
            bus.div_code     <= DIV_CODE_NONE;
            bus.period_valid <= 1'b0;
            bus.locked       <= 1'b0;
            bus.timeout      <= 1'b0;
        end else begin
            cnt              <= cnt_n;
            match_cnt        <= match_cnt_n;
            pend             <= pend_n;
            bus.period       <= period_n;
            bus.div_code     <= div_n;
            bus.period_valid <= pend;
            bus.locked       <= (state == LOCKED);
            bus.timeout      <= to_n;
        end
    end

    // a saturated capture never counts as a match
    assign hit = (cnt != SAT) && (cnt == bus.period);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        match_cnt_n = match_cnt;
        period_n    = bus.period;
        div_n       = bus.div_code;
        pend_n      = 1'b0;
        to_n        = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (rise) begin
                    cnt_n   = CNT_W'(1);
                    state_n = MEASURE;
                end
            end
            default: begin
                if (rise) begin
                    period_n = cnt;
                    div_n    = div_code_of(15'(cnt), CNT_W);
                    pend_n   = 1'b1;
                    cnt_n    = CNT_W'(1);
                    if (hit) begin
                        if (match_cnt != 3'(LOCK_CNT)) begin
                            match_cnt_n = match_cnt + 3'd1;
                        end
                        if (match_cnt_n == 3'(LOCK_CNT)) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        match_cnt_n = '0;
                        state_n     = MEASURE;
                    end
                end else if (cnt != SAT) begin
                    cnt_n = cnt + CNT_W'(1);
                end
`ifdef PERIOD_METER_TIMEOUT_EN
                else begin
                    state_n     = IDLE;
                    cnt_n       = '0;
                    match_cnt_n = '0;
                    to_n        = 1'b1;
                end
`else
                else begin
                    cnt_n = SAT;
                end
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: scoreboard bench; a reference model queues the
// expected pulse on every driven sig_in rise, the monitor checks pulses.
module tb_period_meter;
    import period_meter_pkg::*;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 2;
    localparam int SAT      = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    period_meter_if #(.CNT_W(CNT_W)) bus ();

    period_meter #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int at;
        int p;
        int dc;
        int lk;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit m_idle = 1'b1;
    int m_last = 0;
    int m_prev = 0;
    int m_mc   = 0;
    bit m_lk   = 1'b0;

    int to_count = 0;
    int to_cyc   = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic int div_ref(input int p);
        for (int k = 1; k < CNT_W; k++) begin
            if (p == (1 << k)) return k;
        end
        return 15;
    endfunction

    // model update for a rise driven at the current negedge
    task automatic note_rise();
        int  diff;
        int  p;
        bit  match;
        if (m_idle) begin
            m_idle = 1'b0;
            m_last = cyc;
            return;
        end
        diff   = cyc - m_last;
        m_last = cyc;
`ifdef PERIOD_METER_TIMEOUT_EN
        if (diff > SAT) begin
            m_mc = 0;
            m_lk = 1'b0;
            return;
        end
`endif
        p     = (diff > SAT) ? SAT : diff;
        match = (p != SAT) && (p == m_prev);
        if (match) begin
            if (m_mc < LOCK_CNT) m_mc = m_mc + 1;
        end else begin
            m_mc = 0;
        end
        m_lk   = m_lk ? match : (m_mc == LOCK_CNT);
        m_prev = p;
        sbq.push_back('{cyc + 5, p, div_ref(p), int'(m_lk)});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.period_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("valid_cyc", cyc, e.at);
                    chk("period", bus.period, e.p);
                    chk("div_code", bus.div_code, e.dc);
                    chk("locked", bus.locked, e.lk);
                end
            end
            if (bus.timeout) begin
                to_count++;
                to_cyc = cyc;
            end
        end
    end

    task automatic wave(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sig_in = 1'b1;
            note_rise();
            repeat (hi) @(negedge clk);
            bus.sig_in = 1'b0;
            repeat (per - hi - 1) @(negedge clk);
        end
    endtask

    task automatic settle(input string tag);
        repeat (10) @(negedge clk);
        chk(tag, sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_period", bus.period, 0);
        chk("rst_div", bus.div_code, DIV_CODE_NONE);
        chk("rst_valid", bus.period_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst    = 1'b1;
        m_idle = 1'b1;
        m_prev = 0;
        m_mc   = 0;
        m_lk   = 1'b0;
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_last;
        bus.sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_period", bus.period, 0);
        chk("init_div", bus.div_code, DIV_CODE_NONE);
        chk("init_locked", bus.locked, 0);
        rst = 1'b1;

        // period 2
        wave(2, 1, 6);
        settle("p2_pending");

        // period 16
        do_reset();
        wave(16, 8, 5);
        settle("p16_pending");

        // period 6, not a power of two
        do_reset();
        wave(6, 3, 5);
        settle("p6_pending");

        // locked at 8, switch to 4
        do_reset();
        wave(8, 4, 5);
        chk("p8_locked", bus.locked, 1);
        wave(4, 2, 5);
        settle("p4_pending");

        // long low stretch
        do_reset();
        to_count = 0;
        wave(8, 4, 4);
        c_last = m_last;
        repeat (300) @(negedge clk);
`ifdef PERIOD_METER_TIMEOUT_EN
        chk("to_count", to_count, 1);
        chk("to_cyc", to_cyc, c_last + 259);
        chk("to_locked", bus.locked, 0);
`else
        chk("to_count", to_count, 0);
        chk("sat_locked", bus.locked, 1);
        chk("sat_last", c_last, m_last);
`endif
        wave(8, 4, 3);
        settle("to_pending");

        // reset mid-period
        do_reset();
        wave(6, 3, 4);
        @(negedge clk);
        bus.sig_in = 1'b1;
        note_rise();
        repeat (3) @(negedge clk);
        bus.sig_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_pending", sbq.size(), 0);
        chk("pre_rst_locked", bus.locked, 1);
        do_reset();
        wave(6, 3, 4);
        settle("post_rst_pending");

        chk("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
